pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Control block that drives the PC module's `cmd`/`load_pc` inputs each cycle. It arbitrates redirect requests (trap, jump, branch) against sequential fetch, honours hazard stalls and instruction-memory backpressure, and inserts fixed flush bubbles after every redirect. It sits between the hazard/execute stages and the PC register, in the fetch stage.

## Interface
Parameters:
- `FLUSH_CYCLES`, 2: number of bubble cycles after a redirect (0..15).
- `TRAP_VECTOR`, 32'h0000_0100: absolute trap target.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hazard unit holds fetch.
- `imem_ready`  in  1  instruction memory accepts the fetch this cycle.
- `br_valid`  in  1  taken branch from execute.
- `br_offset`  in  32  offset relative to pc+4.
- `jmp_valid`  in  1  jump request.
- `jmp_target`  in  32  absolute jump target.
- `trap_valid`  in  1  trap request.
- `cmd`  out  pc_cmd_t  to PC: HOLD/INC/INC_OFFSET/LOAD.
- `load_pc`  out  32  to PC `load_pc`.
- `fetch_valid`  out  1  current PC is a real fetch.
- `flush`  out  1  one-cycle pulse: kill younger in-flight instructions.
- `misalign`  out  1  misaligned-target trap pulse.
- `redirect_cnt`  out  16  saturating count of accepted redirects.

## Operation
- States: BOOT, RUN, DRAIN. `rst` asserted: state=BOOT, drain counter=0, `redirect_cnt`=0.
- Outputs while in reset and in BOOT: `cmd`=HOLD, `load_pc`=0, `fetch_valid`=0, `flush`=0, `misalign`=0.
- BOOT: lasts one cycle after reset deassertion, then goes to RUN unconditionally. Redirect inputs are ignored in BOOT.
- RUN redirect priority: trap > jmp > br.
  - trap: `cmd`=LOAD, `load_pc`=TRAP_VECTOR.
  - jmp: `cmd`=LOAD, `load_pc`=jmp_target.
  - br: `cmd`=INC_OFFSET, `load_pc`=br_offset.
- Any accepted redirect in RUN:
  - `flush`=1 and `fetch_valid`=0 that cycle.
  - `redirect_cnt` increments, saturating at 16'hFFFF.
  - Next state is DRAIN with counter=FLUSH_CYCLES. If FLUSH_CYCLES=0, next state is RUN.
- RUN, no redirect:
  - `fetch_valid`=!stall.
  - `cmd`=INC iff !stall && imem_ready, else HOLD.
  - `load_pc`=0.
- DRAIN:
  - `cmd`=HOLD, `fetch_valid`=0, `flush`=0; counter decrements each cycle.
  - Moves to RUN in the cycle after the counter reaches 1.
  - jmp/br are ignored (they come from flushed instructions).
  - trap is accepted: performs the same trap redirect as in RUN and reloads the counter.
- Simultaneous requests: only the highest-priority request acts. Lower ones are dropped, not queued.
- Reset mid-DRAIN or mid-redirect: immediate return to BOOT. Counter and state are cleared asynchronously.

## Timing
- `cmd`, `load_pc`, `fetch_valid`, `flush`, `misalign` are combinational from state and inputs. The PC register reflects a redirect on the next rising edge, so latency is one cycle from request to new PC.
- Redirect to first valid fetch: 1 + FLUSH_CYCLES cycles.
- State, counter and `redirect_cnt` are registered on the `clk` rising edge. `rst` acts asynchronously on these registers.
- `flush` and `misalign` are high for exactly one cycle per event.

## Configuration
- `PC_SEQ_ALIGN_CHECK_EN` defined:
  - A jmp with jmp_target[1:0]!=0, or a br with br_offset[1:0]!=0, is converted to a trap redirect: `cmd`=LOAD, `load_pc`=TRAP_VECTOR, `misalign`=1 that cycle.
  - `flush` and DRAIN behave exactly as for a normal redirect.
- Undefined: targets and offsets pass through unchecked, and `misalign` is tied to 0.

## Test plan
- Reset released, `stall`=0, `imem_ready`=1 -> one BOOT cycle (`cmd`=HOLD, `fetch_valid`=0), then `cmd`=INC and `fetch_valid`=1 every cycle.
- In RUN, `br_valid`=1 with br_offset=32'h10 -> `cmd`=INC_OFFSET, `load_pc`=32'h10, `flush`=1 for one cycle. Then two cycles of HOLD with `fetch_valid`=0, then INC. `redirect_cnt` increments by 1.
- Same cycle trap_valid=1, jmp_valid=1 (jmp_target=32'h200), br_valid=1 -> `load_pc`=32'h100, `cmd`=LOAD. The jmp and br are dropped.
- In DRAIN, jmp_valid=1 -> ignored. trap_valid=1 -> LOAD 32'h100, `flush`=1, counter reloads to 2.
- `stall`=1 with `imem_ready`=1 -> `cmd`=HOLD, `fetch_valid`=0. `stall`=0 with `imem_ready`=0 -> `cmd`=HOLD, `fetch_valid`=1.
- With `PC_SEQ_ALIGN_CHECK_EN`, jmp_target=32'h202 -> `cmd`=LOAD, `load_pc`=32'h100, `misalign`=1 for one cycle. Without the macro -> `load_pc`=32'h202, `misalign`=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: arbitrates trap/jump/branch redirects against sequential fetch and
// inserts flush bubbles after each redirect. Define PC_SEQ_ALIGN_CHECK_EN to trap misaligned targets.
module pc_sequencer #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        imem_ready_i,
    input  logic        br_valid_i,
    input  logic [31:0] br_offset_i,
    input  logic        jmp_valid_i,
    input  logic [31:0] jmp_target_i,
    input  logic        trap_valid_i,
    output logic [1:0]  cmd_o,
    output logic [31:0] load_pc_o,
    output logic        fetch_valid_o,
    output logic        flush_o,
    output logic        misalign_o,
    output logic [15:0] redirect_cnt_o
);

    // PC command encoding shared with the PC register.
    localparam logic [1:0] CmdHold      = 2'd0;
    localparam logic [1:0] CmdInc       = 2'd1;
    localparam logic [1:0] CmdIncOffset = 2'd2;
    localparam logic [1:0] CmdLoad      = 2'd3;

    localparam logic [3:0] FlushCnt = 4'(FLUSH_CYCLES);

`ifdef PC_SEQ_ALIGN_CHECK_EN
    localparam bit AlignCheck = 1'b1;
`else
    localparam bit AlignCheck = 1'b0;
`endif

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StDrain
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] redirect_cnt_q, redirect_cnt_d;

    logic jmp_misaligned;
    logic br_misaligned;
    logic redirect;

    assign jmp_misaligned = AlignCheck && (jmp_target_i[1:0] != 2'b00);
    assign br_misaligned  = AlignCheck && (br_offset_i[1:0] != 2'b00);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_o         = CmdHold;
        load_pc_o     = 32'h0;
        fetch_valid_o = 1'b0;
        flush_o       = 1'b0;
        misalign_o    = 1'b0;
        redirect      = 1'b0;

        unique case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun: begin
                if (trap_valid_i) begin
                    redirect  = 1'b1;
                    cmd_o     = CmdLoad;
                    load_pc_o = TRAP_VECTOR;
                end else if (jmp_valid_i) begin
                    redirect   = 1'b1;
                    cmd_o      = CmdLoad;
                    load_pc_o  = jmp_misaligned ? TRAP_VECTOR : jmp_target_i;
                    misalign_o = jmp_misaligned;
                end else if (br_valid_i) begin
                    redirect   = 1'b1;
                    misalign_o = br_misaligned;
                    if (br_misaligned) begin
                        cmd_o     = CmdLoad;
                        load_pc_o = TRAP_VECTOR;
                    end else begin
                        cmd_o     = CmdIncOffset;
                        load_pc_o = br_offset_i;
                    end
                end else begin
                    fetch_valid_o = !stall_i;
                    cmd_o         = (!stall_i && imem_ready_i) ? CmdInc : CmdHold;
                end
            end
            StDrain: begin
                // jmp/br here belong to instructions being flushed; only a trap is honoured.
                if (trap_valid_i) begin
                    redirect  = 1'b1;
                    cmd_o     = CmdLoad;
                    load_pc_o = TRAP_VECTOR;
                end else if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StBoot;
                cnt_d   = 4'd0;
            end
        endcase

        if (redirect) begin
            flush_o = 1'b1;
            if (FlushCnt == 4'd0) begin
                state_d = StRun;
                cnt_d   = 4'd0;
            end else begin
                state_d = StDrain;
                cnt_d   = FlushCnt;
            end
        end
    end

    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        if (redirect && (redirect_cnt_q != 16'hFFFF)) begin
            redirect_cnt_d = redirect_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= StBoot;
            cnt_q          <= 4'd0;
            redirect_cnt_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign redirect_cnt_o = redirect_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed test-plan cases plus randomized traffic
// compared each cycle against a behavioural model of the sequencing rules.
module tb_pc_sequencer;

    localparam int unsigned FLUSH = 2;
    localparam logic [31:0] TVEC  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        imem_ready = 1'b1;
    logic        br_valid = 1'b0;
    logic [31:0] br_offset = 32'h0;
    logic        jmp_valid = 1'b0;
    logic [31:0] jmp_target = 32'h0;
    logic        trap_valid = 1'b0;
    logic [1:0]  cmd;
    logic [31:0] load_pc;
    logic        fetch_valid;
    logic        flush;
    logic        misalign;
    logic [15:0] redirect_cnt;

    pc_sequencer #(
        .FLUSH_CYCLES(FLUSH),
        .TRAP_VECTOR (TVEC)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .imem_ready_i  (imem_ready),
        .br_valid_i    (br_valid),
        .br_offset_i   (br_offset),
        .jmp_valid_i   (jmp_valid),
        .jmp_target_i  (jmp_target),
        .trap_valid_i  (trap_valid),
        .cmd_o         (cmd),
        .load_pc_o     (load_pc),
        .fetch_valid_o (fetch_valid),
        .flush_o       (flush),
        .misalign_o    (misalign),
        .redirect_cnt_o(redirect_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: fresh-out-of-reset flag, remaining bubble cycles, redirect tally.
    bit m_boot    = 1'b1;
    int m_bubbles = 0;
    int m_count   = 0;

`ifdef PC_SEQ_ALIGN_CHECK_EN
    localparam bit AlignEn = 1'b1;
`else
    localparam bit AlignEn = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input bit s, input bit r, input bit t, input bit j, input logic [31:0] jt,
                         input bit b, input logic [31:0] bo);
        stall      = s;
        imem_ready = r;
        trap_valid = t;
        jmp_valid  = j;
        jmp_target = jt;
        br_valid   = b;
        br_offset  = bo;
    endtask

    // Compare the DUT against the model for the current cycle, then advance the model.
    task automatic step();
        logic [1:0]  e_cmd;
        logic [31:0] e_pc;
        bit          e_fv, e_fl, e_mis, redir;
        e_cmd = 2'd0; e_pc = 32'h0; e_fv = 0; e_fl = 0; e_mis = 0; redir = 0;
        chk("redirect_cnt", 32'(redirect_cnt), 32'(m_count));
        if (m_boot) begin
            m_boot = 0;
        end else if (m_bubbles > 0) begin
            if (trap_valid) begin
                redir = 1; e_cmd = 2'd3; e_pc = TVEC;
            end else begin
                m_bubbles = m_bubbles - 1;
            end
        end else if (trap_valid) begin
            redir = 1; e_cmd = 2'd3; e_pc = TVEC;
        end else if (jmp_valid) begin
            redir = 1; e_cmd = 2'd3;
            e_mis = AlignEn && (jmp_target % 4 != 0);
            e_pc  = e_mis ? TVEC : jmp_target;
        end else if (br_valid) begin
            redir = 1;
            e_mis = AlignEn && (br_offset % 4 != 0);
            e_cmd = e_mis ? 2'd3 : 2'd2;
            e_pc  = e_mis ? TVEC : br_offset;
        end else begin
            e_fv  = !stall;
            e_cmd = (!stall && imem_ready) ? 2'd1 : 2'd0;
        end
        if (redir) begin
            e_fl      = 1;
            m_bubbles = FLUSH;
            m_count   = (m_count < 65535) ? m_count + 1 : 65535;
        end
        chk("cmd", 32'(cmd), 32'(e_cmd));
        chk("load_pc", load_pc, e_pc);
        chk("fetch_valid", 32'(fetch_valid), 32'(e_fv));
        chk("flush", 32'(flush), 32'(e_fl));
        chk("misalign", 32'(misalign), 32'(e_mis));
    endtask

    task automatic lit(input string name, input logic [1:0] c, input logic [31:0] pc,
                       input bit fv, input bit fl);
        chk({name, ".cmd"}, 32'(cmd), 32'(c));
        chk({name, ".load_pc"}, load_pc, pc);
        chk({name, ".fetch_valid"}, 32'(fetch_valid), 32'(fv));
        chk({name, ".flush"}, 32'(flush), 32'(fl));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert reset asynchronously mid-cycle, check the cleared outputs, release after an edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        lit("in_reset", 2'd0, 32'h0, 1'b0, 1'b0);
        chk("in_reset.redirect_cnt", 32'(redirect_cnt), 32'h0);
        chk("in_reset.misalign", 32'(misalign), 32'h0);
        tick();
        rst       = 1'b0;
        m_boot    = 1'b1;
        m_bubbles = 0;
        m_count   = 0;
    endtask

    task automatic cycle();
        #3;
        step();
    endtask

    initial begin
        drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
        tick();
        do_reset();

        drive(0, 1, 0, 0, 32'h0, 0, 32'h0); cycle(); lit("boot", 2'd0, 32'h0, 0, 0); tick();
        drive(0, 1, 0, 0, 32'h0, 0, 32'h0); cycle(); lit("run_inc", 2'd1, 32'h0, 1, 0); tick();
        drive(0, 1, 0, 0, 32'h0, 1, 32'h10); cycle(); lit("br", 2'd2, 32'h10, 0, 1); tick();
        drive(0, 1, 0, 0, 32'h0, 0, 32'h0); cycle(); lit("bubble1", 2'd0, 32'h0, 0, 0); tick();
        drive(0, 1, 0, 0, 32'h0, 0, 32'h0); cycle(); lit("bubble2", 2'd0, 32'h0, 0, 0); tick();
        drive(0, 1, 0, 0, 32'h0, 0, 32'h0); cycle(); lit("resume", 2'd1, 32'h0, 1, 0);
        chk("cnt_after_br", 32'(redirect_cnt), 32'd1); tick();
        drive(0, 1, 1, 1, 32'h200, 1, 32'h40); cycle(); lit("prio", 2'd3, 32'h100, 0, 1); tick();
        drive(0, 1, 0, 1, 32'h300, 0, 32'h0); cycle(); lit("drain_jmp", 2'd0, 32'h0, 0, 0); tick();
        drive(0, 1, 1, 0, 32'h0, 0, 32'h0); cycle(); lit("drain_trap", 2'd3, 32'h100, 0, 1); tick();
        drive(0, 1, 0, 0, 32'h0, 0, 32'h0); cycle(); lit("reload1", 2'd0, 32'h0, 0, 0); tick();
        drive(0, 1, 0, 0, 32'h0, 0, 32'h0); cycle(); lit("reload2", 2'd0, 32'h0, 0, 0); tick();
        drive(0, 1, 0, 0, 32'h0, 0, 32'h0); cycle(); lit("resume2", 2'd1, 32'h0, 1, 0);
        chk("cnt_after_traps", 32'(redirect_cnt), 32'd3); tick();
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0); cycle(); lit("stall", 2'd0, 32'h0, 0, 0); tick();
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0); cycle(); lit("not_ready", 2'd0, 32'h0, 1, 0); tick();
        drive(0, 1, 0, 1, 32'h202, 0, 32'h0); cycle();
        if (AlignEn) begin
            lit("mis_jmp", 2'd3, 32'h100, 0, 1);
            chk("mis_jmp.misalign", 32'(misalign), 32'h1);
        end else begin
            lit("mis_jmp", 2'd3, 32'h202, 0, 1);
            chk("mis_jmp.misalign", 32'(misalign), 32'h0);
        end
        tick();
        drive(0, 1, 0, 0, 32'h0, 0, 32'h0); cycle(); chk("mis_pulse", 32'(misalign), 32'h0);
        tick();

        for (int i = 0; i < 3000; i++) begin
            if (m_bubbles > 0 && $urandom_range(0, 150) == 0) begin
                do_reset();
            end
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) ? ($urandom & 32'hFFFF_FFFC) : $urandom,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) ? ($urandom & 32'hFFFF_FFFC) : $urandom);
            cycle();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
